// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer stage: registered in_ready/out_valid, strict FIFO order,
// full throughput under continuous flow, synchronous flush and async active-low reset.
module pipe_skid_stage #(
    parameter int WIDTH = 75
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] main_q, main_nxt;
    logic [WIDTH-1:0] skid_q, skid_nxt;
    logic             push, pop;

    // Handshake outputs come from state alone, so there is no ready/valid combinational path.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign occupancy = state;
    assign out_data  = main_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            // Only the valid state is cleared; payload registers keep their contents.
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_nxt = ONE;
                        main_nxt  = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_nxt = in_data;
                    end else if (push) begin
                        state_nxt = TWO;
                        skid_nxt  = in_data;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_nxt = ONE;
                        main_nxt  = skid_q;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_pipe_skid_stage;

    localparam int WIDTH = 75;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    int n_chk  = 0;
    int n_fail = 0;

    pipe_skid_stage #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded queue of at most two entries.
    logic [WIDTH-1:0] q[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
        end else begin
            bit do_push, do_pop;
            do_push = in_valid && (q.size() < 2);
            do_pop  = out_ready && (q.size() > 0);
            if (flush) begin
                q.delete();
            end else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back(in_data);
            end
        end
    end

    // Per-cycle compare against the model, plus hold-stability under backpressure.
    logic             hold_prev = 1'b0;
    logic [WIDTH-1:0] od_prev;

    always @(negedge clk) begin
        chk("occupancy", occupancy, q.size());
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() != 0) chk("out_data", out_data, q[0]);
        if (!reset) chk("out_data_in_reset", out_data, 0);
        if (hold_prev && out_valid) chk("out_data_stable", out_data, od_prev);
        hold_prev = reset && out_valid && !out_ready && !flush;
        od_prev   = out_data;
    end

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [95:0] rnd;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // single push, consumer stalled
        drive(1, 'h1F, 0, 0);
        chk("t30_out_valid", out_valid, 1);
        chk("t30_out_data", out_data, 'h1F);
        chk("t30_occupancy", occupancy, 1);
        chk("t30_in_ready", in_ready, 1);
        drive(0, 0, 1, 0);
        chk("t30_drained", occupancy, 0);

        // fill to two, hold off a third, then drain
        drive(1, 'h1, 0, 0);
        drive(1, 'h2, 0, 0);
        chk("t31_occupancy", occupancy, 2);
        chk("t31_in_ready", in_ready, 0);
        chk("t31_out_data", out_data, 'h1);
        drive(1, 'h3, 0, 0);
        chk("t31_held_occ", occupancy, 2);
        chk("t31_held_data", out_data, 'h1);
        drive(1, 'h3, 1, 0);
        chk("t31_second_out", out_data, 'h2);
        chk("t31_second_occ", occupancy, 1);
        drive(1, 'h3, 1, 0);
        chk("t31_third_out", out_data, 'h3);
        chk("t31_third_occ", occupancy, 1);
        drive(0, 0, 1, 0);

        // full-rate streaming
        for (int i = 0; i < 100; i++) begin
            drive(1, WIDTH'(i), 1, 0);
            chk("t32_out_data", out_data, i);
            chk("t32_out_valid", out_valid, 1);
            chk("t32_in_ready", in_ready, 1);
        end
        drive(0, 0, 1, 0);
        chk("t32_drained", occupancy, 0);

        // flush from TWO with simultaneous push and pop
        drive(1, 'hA, 0, 0);
        drive(1, 'hB, 0, 0);
        drive(1, 'hC, 1, 1);
        chk("t34_occupancy", occupancy, 0);
        chk("t34_out_valid", out_valid, 0);
        chk("t34_in_ready", in_ready, 1);
        chk("t34_main_kept", out_data, 'hA);
        drive(0, 0, 1, 0);
        chk("t34_still_empty", out_valid, 0);
        drive(1, 'hD, 0, 0);
        chk("t34_next_data", out_data, 'hD);
        drive(0, 0, 1, 0);

        // async reset mid-cycle from TWO
        drive(1, 'h55, 0, 0);
        drive(1, 'h66, 0, 0);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("t35_out_valid", out_valid, 0);
        chk("t35_occupancy", occupancy, 0);
        chk("t35_out_data", out_data, 0);
        chk("t35_in_ready", in_ready, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1, 'h77, 0, 0);
        chk("t28_accept", out_valid, 1);
        chk("t28_data", out_data, 'h77);
        drive(0, 0, 1, 0);

        // random traffic, model checks every cycle
        for (int i = 0; i < 10000; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            drive(1'($urandom_range(0, 1)), rnd[WIDTH-1:0], 1'($urandom_range(0, 1)), 0);
        end
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        chk("final_empty", occupancy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
